// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_DEPTH      = 2;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small flushable FIFO; head is visible combinationally, push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they exist.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Credit-limited instruction fetch: requests, in-flight PC tracking, redirect flush.
// Response in cycle N is presented in N+1; stall holds the head, credits throttle requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW:0] sum_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] ifo_count, pq_count;
  fetch_entry_t  ifo_head, ifo_push_dat;
  logic [31:0]   pq_head;
  logic          credit_ok, req_vld, req_fire;
  logic          rsp_acc, rsp_drop, rsp_live;
  logic          ifo_vld, ifo_push, ifo_pop, pq_pop;

  always_comb begin
    credit_ok = (sum_t'(outstanding_q) + sum_t'(ifo_count)) < sum_t'(DEPTH);
    // rst gates the request so it drops the moment reset asserts.
    req_vld   = rst && !redirect && credit_ok;
    req_fire  = req_vld && imem_req_ready;
    rsp_acc   = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop  = rsp_acc && (drop_cnt_q != '0);
    rsp_live  = rsp_acc && (drop_cnt_q == '0) && (pq_count != '0);
    ifo_vld   = (ifo_count != '0);
    ifo_pop   = ifo_vld && !stall && !redirect;
    ifo_push  = rsp_live && !redirect;
    pq_pop    = rsp_live && !redirect;
    ifo_push_dat.pc    = pq_head;
    ifo_push_dat.instr = imem_rsp_data;

    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      // Everything still in flight becomes a response to throw away.
      fetch_pc_d    = align_pc(redirect_pc);
      outstanding_d = outstanding_q - CW'(rsp_acc);
      drop_cnt_d    = outstanding_q - CW'(rsp_acc);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INCR;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_acc);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (ifo_push),
    .push_dat_i (ifo_push_dat),
    .pop_i      (ifo_pop),
    .pop_dat_o  (ifo_head),
    .count_o    (ifo_count)
  );

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (req_fire),
    .push_dat_i (fetch_pc_q),
    .pop_i      (pq_pop),
    .pop_dat_o  (pq_head),
    .count_o    (pq_count)
  );

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = fetch_pc_q;
  assign if_valid       = ifo_vld;
  assign if_pc          = ifo_vld ? ifo_head.pc    : 32'h0;
  assign if_instr       = ifo_vld ? ifo_head.instr : 32'h0;

endmodule
